// File: rtl/grid_render_pkg.sv
// grid_render_pkg: default geometry, pitch constants, pixel coordinate widths
// and small helpers shared by the grid sprite renderer files.
package grid_render_pkg;

   localparam int DEF_GRID_ROWS   = 5;
   localparam int DEF_GRID_COLS   = 10;
   localparam int DEF_CELL_W      = 30;
   localparam int DEF_CELL_H      = 20;
   localparam int DEF_GAP_X       = 10;
   localparam int DEF_GAP_Y       = 10;
   localparam int DEF_PLAYER_W    = 30;
   localparam int DEF_PLAYER_H    = 20;
   localparam int DEF_NUM_BULLETS = 4;
   localparam int DEF_BULLET_W    = 2;
   localparam int DEF_BULLET_H    = 8;

   localparam int DEF_PITCH_X = DEF_CELL_W + DEF_GAP_X;
   localparam int DEF_PITCH_Y = DEF_CELL_H + DEF_GAP_Y;

   // Column positions and both pixel counters are 10 bits, row positions 9,
   // and every right/bottom bound is formed 11 bits wide so it cannot wrap.
   localparam int POS_X_W = 10;
   localparam int POS_Y_W = 9;
   localparam int EXT_W   = 11;

   function automatic int clog2(input int value);
      int result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) result++;
      return result;
   endfunction

   // Index width that stays at least one bit for single-entry ranges
   function automatic int idx_width(input int count);
      return (clog2(count) > 0) ? clog2(count) : 1;
   endfunction

   // Half-open span test start <= pos < start + len, all at the wide width
   function automatic logic in_span(input logic [EXT_W-1:0] pos,
                                    input logic [EXT_W-1:0] start,
                                    input logic [EXT_W-1:0] len);
      return (pos >= start) && (pos < start + len);
   endfunction

endpackage

// File: rtl/grid_cell_locator.sv
// grid_cell_locator: maps an offset from the grid origin onto a cell index
// along one axis using parallel compares against multiples of the pitch.
module grid_cell_locator
   import grid_render_pkg::*;
#(
   parameter int PITCH = DEF_PITCH_X,
   parameter int SIZE  = DEF_CELL_W,
   parameter int COUNT = DEF_GRID_COLS,
   parameter int IDX_W = idx_width(DEF_GRID_COLS)
)(
   input  logic [EXT_W-1:0] offset,
   output logic [IDX_W-1:0] index,
   output logic             in_sprite,
   output logic             in_range
);

   genvar gi;

   logic [COUNT-1:0] at_or_past;
   logic [31:0]      offset_w;
   logic [31:0]      cell_base;

   assign offset_w = 32'(offset);

   for (gi = 0; gi < COUNT; gi++) begin : g_threshold
      assign at_or_past[gi] = offset_w >= 32'(gi * PITCH);
   end

   // The highest threshold crossed selects the cell and its left/top edge
   always_comb begin
      index     = '0;
      cell_base = '0;
      for (int k = 0; k < COUNT; k++) begin
         if (at_or_past[k]) begin
            index     = IDX_W'(k);
            cell_base = 32'(k * PITCH);
         end
      end
   end

   assign in_range  = offset_w < 32'(COUNT * PITCH);
   assign in_sprite = (offset_w - cell_base) < 32'(SIZE);

endmodule

// File: rtl/grid_sprite_renderer.sv
// grid_sprite_renderer: 3-stage pixel pipeline drawing an alien grid (R),
// a player (G) and bullets (B) from per-frame shadow copies of the inputs.
// Optional feature macro GRID_RENDER_COLLISION_EN adds per-bullet alien-hit
// reporting on CollisionMask; without it CollisionMask is tied to 0.
module grid_sprite_renderer
   import grid_render_pkg::*;
#(
   parameter int GRID_ROWS   = DEF_GRID_ROWS,
   parameter int GRID_COLS   = DEF_GRID_COLS,
   parameter int CELL_W      = DEF_CELL_W,
   parameter int CELL_H      = DEF_CELL_H,
   parameter int GAP_X       = DEF_GAP_X,
   parameter int GAP_Y       = DEF_GAP_Y,
   parameter int PLAYER_W    = DEF_PLAYER_W,
   parameter int PLAYER_H    = DEF_PLAYER_H,
   parameter int NUM_BULLETS = DEF_NUM_BULLETS,
   parameter int BULLET_W    = DEF_BULLET_W,
   parameter int BULLET_H    = DEF_BULLET_H
)(
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           FrameStart,
   input  logic [GRID_ROWS*GRID_COLS-1:0] Aliens_Grid,
   input  logic [POS_Y_W-1:0]             AliensRow,
   input  logic [POS_X_W-1:0]             AliensCol,
   input  logic [POS_Y_W-1:0]             PlayerRow,
   input  logic [POS_X_W-1:0]             PlayerCol,
   input  logic [POS_Y_W*NUM_BULLETS-1:0] BulletRow,
   input  logic [POS_X_W*NUM_BULLETS-1:0] BulletCol,
   input  logic [NUM_BULLETS-1:0]         BulletExists,
   input  logic [POS_X_W-1:0]             CounterX,
   input  logic [POS_X_W-1:0]             CounterY,
   input  logic                           inDisplayArea,
   output logic                           R,
   output logic                           G,
   output logic                           B,
   output logic [NUM_BULLETS-1:0]         CollisionMask
);

   genvar gi;

   localparam int PITCH_X    = CELL_W + GAP_X;
   localparam int PITCH_Y    = CELL_H + GAP_Y;
   localparam int COL_W      = idx_width(GRID_COLS);
   localparam int ROW_W      = idx_width(GRID_ROWS);
   localparam int CELLS      = GRID_ROWS * GRID_COLS;
   localparam int CELL_IDX_W = idx_width(CELLS);

   logic [CELLS-1:0]               grid_reg;
   logic [POS_Y_W-1:0]             aliens_row_reg, player_row_reg;
   logic [POS_X_W-1:0]             aliens_col_reg, player_col_reg;
   logic [POS_Y_W*NUM_BULLETS-1:0] bullet_row_reg;
   logic [POS_X_W*NUM_BULLETS-1:0] bullet_col_reg;
   logic [NUM_BULLETS-1:0]         bullet_exists_reg;

   // Shadow copies taken at frame start; FrameStart arrives in vertical
   // blank, so pixels still in flight at that moment are invisible anyway
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         grid_reg          <= '0;
         aliens_row_reg    <= '0;
         aliens_col_reg    <= '0;
         player_row_reg    <= '0;
         player_col_reg    <= '0;
         bullet_row_reg    <= '0;
         bullet_col_reg    <= '0;
         bullet_exists_reg <= '0;
      end else if (FrameStart) begin
         grid_reg          <= Aliens_Grid;
         aliens_row_reg    <= AliensRow;
         aliens_col_reg    <= AliensCol;
         player_row_reg    <= PlayerRow;
         player_col_reg    <= PlayerCol;
         bullet_row_reg    <= BulletRow;
         bullet_col_reg    <= BulletCol;
         bullet_exists_reg <= BulletExists;
      end
   end

   // ---------------- Stage 1: offsets from the grid origin ----------------
   logic [EXT_W-1:0]   dx_next, dy_next, dx_reg, dy_reg;
   logic               x_borrow_reg, y_borrow_reg, vis1_reg;
   logic [POS_X_W-1:0] px_reg, py_reg;

   assign dx_next = {1'b0, CounterX} - {1'b0, aliens_col_reg};
   assign dy_next = {1'b0, CounterY} - {2'b0, aliens_row_reg};

   // Register offsets, their borrow (pixel left of / above the grid) and the pixel
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         dx_reg       <= '0;
         dy_reg       <= '0;
         x_borrow_reg <= 1'b0;
         y_borrow_reg <= 1'b0;
         px_reg       <= '0;
         py_reg       <= '0;
         vis1_reg     <= 1'b0;
      end else begin
         dx_reg       <= dx_next;
         dy_reg       <= dy_next;
         x_borrow_reg <= dx_next[EXT_W-1];
         y_borrow_reg <= dy_next[EXT_W-1];
         px_reg       <= CounterX;
         py_reg       <= CounterY;
         vis1_reg     <= inDisplayArea;
      end
   end

   // ---------------- Stage 2: cell resolve, player/bullet compares --------
   logic [COL_W-1:0]       col_next, col_reg;
   logic [ROW_W-1:0]       row_next, row_reg;
   logic                   x_sprite, x_range, y_sprite, y_range;
   logic                   player_next;
   logic [NUM_BULLETS-1:0] bullet_next;

   grid_cell_locator #(
      .PITCH (PITCH_X), .SIZE (CELL_W), .COUNT (GRID_COLS), .IDX_W (COL_W)
   ) u_loc_x (
      .offset (dx_reg), .index (col_next), .in_sprite (x_sprite), .in_range (x_range)
   );

   grid_cell_locator #(
      .PITCH (PITCH_Y), .SIZE (CELL_H), .COUNT (GRID_ROWS), .IDX_W (ROW_W)
   ) u_loc_y (
      .offset (dy_reg), .index (row_next), .in_sprite (y_sprite), .in_range (y_range)
   );

   assign player_next = in_span({1'b0, px_reg}, {1'b0, player_col_reg}, EXT_W'(PLAYER_W)) &&
                        in_span({1'b0, py_reg}, {2'b0, player_row_reg}, EXT_W'(PLAYER_H));

   for (gi = 0; gi < NUM_BULLETS; gi++) begin : g_bullet
      assign bullet_next[gi] = bullet_exists_reg[gi] &&
         in_span({1'b0, px_reg}, {1'b0, bullet_col_reg[gi*POS_X_W +: POS_X_W]}, EXT_W'(BULLET_W)) &&
         in_span({1'b0, py_reg}, {2'b0, bullet_row_reg[gi*POS_Y_W +: POS_Y_W]}, EXT_W'(BULLET_H));
   end

   logic                   x_in_reg, y_in_reg, player_reg, vis2_reg;
   logic [NUM_BULLETS-1:0] bullet_reg;

   // Register per-axis "inside a live-able sprite" flags and shape compares
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         col_reg    <= '0;
         row_reg    <= '0;
         x_in_reg   <= 1'b0;
         y_in_reg   <= 1'b0;
         player_reg <= 1'b0;
         bullet_reg <= '0;
         vis2_reg   <= 1'b0;
      end else begin
         col_reg    <= col_next;
         row_reg    <= row_next;
         x_in_reg   <= x_sprite & x_range & ~x_borrow_reg;
         y_in_reg   <= y_sprite & y_range & ~y_borrow_reg;
         player_reg <= player_next;
         bullet_reg <= bullet_next;
         vis2_reg   <= vis1_reg;
      end
   end

   // ---------------- Stage 3: grid lookup and colour outputs -------------
   logic [CELL_IDX_W-1:0] cell_idx;
   logic                  alien_hit;

   // The locators never report an index past the last cell, so this stays in range
   assign cell_idx  = CELL_IDX_W'(32'(row_reg) * 32'(GRID_COLS) + 32'(col_reg));
   assign alien_hit = vis2_reg & x_in_reg & y_in_reg & grid_reg[cell_idx];

   // Colour outputs, each independently masked by the delayed display qualifier
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         R <= 1'b0;
         G <= 1'b0;
         B <= 1'b0;
      end else begin
         R <= alien_hit;
         G <= vis2_reg & player_reg;
         B <= vis2_reg & (|bullet_reg);
      end
   end

`ifdef GRID_RENDER_COLLISION_EN
   logic [NUM_BULLETS-1:0] hit_acc_reg;
   logic [NUM_BULLETS-1:0] hit_now;

   assign hit_now = {NUM_BULLETS{alien_hit}} & bullet_reg;

   // Sticky per-bullet hits; a hit on the FrameStart cycle belongs to the new frame
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hit_acc_reg   <= '0;
         CollisionMask <= '0;
      end else if (FrameStart) begin
         CollisionMask <= hit_acc_reg;
         hit_acc_reg   <= hit_now;
      end else begin
         hit_acc_reg   <= hit_acc_reg | hit_now;
      end
   end
`else
   assign CollisionMask = '0;
`endif

endmodule

// File: tb/tb_grid_sprite_renderer.sv
// tb_grid_sprite_renderer: directed vectors for grid_sprite_renderer with a
// geometric reference model checked every cycle plus literal pixel probes.
// Build with GRID_RENDER_COLLISION_EN defined to exercise CollisionMask hits.
module tb_grid_sprite_renderer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        FrameStart;
   logic [49:0] Aliens_Grid;
   logic [8:0]  AliensRow, PlayerRow;
   logic [9:0]  AliensCol, PlayerCol;
   logic [35:0] BulletRow;
   logic [39:0] BulletCol;
   logic [3:0]  BulletExists;
   logic [9:0]  CounterX, CounterY;
   logic        inDisplayArea;
   logic        R, G, B;
   logic [3:0]  CollisionMask;

   grid_sprite_renderer dut (
      .Clk (Clk), .Reset (Reset), .FrameStart (FrameStart), .Aliens_Grid (Aliens_Grid),
      .AliensRow (AliensRow), .AliensCol (AliensCol), .PlayerRow (PlayerRow), .PlayerCol (PlayerCol),
      .BulletRow (BulletRow), .BulletCol (BulletCol), .BulletExists (BulletExists),
      .CounterX (CounterX), .CounterY (CounterY), .inDisplayArea (inDisplayArea),
      .R (R), .G (G), .B (B), .CollisionMask (CollisionMask)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       r;
      logic       g;
      logic       b;
      logic [3:0] hit;
   } exp_t;

   logic [49:0] m_grid;
   int          m_ac, m_ar, m_pc, m_pr;
   int          m_bc [4];
   int          m_br [4];
   logic [3:0]  m_be;
   logic [3:0]  m_mask;
`ifdef GRID_RENDER_COLLISION_EN
   logic [3:0]  m_acc;
`endif
   exp_t        p0, p1, p2;

   function automatic bit in_rect(int x, int y, int rx, int ry, int w, int h);
      return (x >= rx) && (x < rx + w) && (y >= ry) && (y < ry + h);
   endfunction

   // What the screen shows at (x,y): 30x20 aliens on a 40x30 pitch, 10x5 grid
   function automatic exp_t model_pixel(int x, int y, bit vis);
      exp_t e;
      int   ox, oy;
      e = '0;
      if (x >= m_ac && y >= m_ar) begin
         ox = x - m_ac;
         oy = y - m_ar;
         if (ox / 40 < 10 && oy / 30 < 5 && ox % 40 < 30 && oy % 30 < 20)
            e.r = m_grid[(oy / 30) * 10 + ox / 40];
      end
      e.g = in_rect(x, y, m_pc, m_pr, 30, 20);
      for (int i = 0; i < 4; i++)
         e.hit[i] = m_be[i] && in_rect(x, y, m_bc[i], m_br[i], 2, 8);
      e.b = |e.hit;
      if (!e.r) e.hit = '0;
      if (!vis) e = '0;
      return e;
   endfunction

   // Model advances on the clock; p2 is what the outputs must show now
   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         p0 <= '0; p1 <= '0; p2 <= '0;
         m_grid <= '0; m_ac <= 0; m_ar <= 0; m_pc <= 0; m_pr <= 0; m_be <= '0;
         for (int i = 0; i < 4; i++) begin
            m_bc[i] <= 0;
            m_br[i] <= 0;
         end
         m_mask <= '0;
`ifdef GRID_RENDER_COLLISION_EN
         m_acc <= '0;
`endif
      end else begin
         p0 <= model_pixel(int'(CounterX), int'(CounterY), inDisplayArea);
         p1 <= p0;
         p2 <= p1;
`ifdef GRID_RENDER_COLLISION_EN
         if (FrameStart) begin
            m_mask <= m_acc;
            m_acc  <= p1.hit;
         end else begin
            m_acc  <= m_acc | p1.hit;
         end
`endif
         if (FrameStart) begin
            m_grid <= Aliens_Grid;
            m_ac <= int'(AliensCol); m_ar <= int'(AliensRow);
            m_pc <= int'(PlayerCol); m_pr <= int'(PlayerRow);
            m_be <= BulletExists;
            for (int i = 0; i < 4; i++) begin
               m_bc[i] <= int'(BulletCol[i*10 +: 10]);
               m_br[i] <= int'(BulletRow[i*9 +: 9]);
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge Clk) begin
      if (checking && !Reset) begin
         check("rgb_model", 32'({R, G, B}), 32'({p2.r, p2.g, p2.b}));
         check("mask_model", 32'(CollisionMask), 32'(m_mask));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic put(input int x, input int y, input bit vis);
      CounterX = 10'(x);
      CounterY = 10'(y);
      inDisplayArea = vis;
      @(negedge Clk);
   endtask

   task automatic frame();
      repeat (3) put(0, 0, 0);
      FrameStart = 1'b1;
      put(0, 0, 0);
      FrameStart = 1'b0;
      repeat (3) put(0, 0, 0);
   endtask

   // One pixel between blanks: nothing on the cycle before, the colour 3 cycles on
   task automatic probe(input string name, input int x, input int y, input bit vis,
                        input logic [2:0] want);
      put(0, 0, 0);
      put(x, y, vis);
      put(0, 0, 0);
      check({name, "_latency"}, 32'({R, G, B}), 32'(0));
      put(0, 0, 0);
      check(name, 32'({R, G, B}), 32'(want));
      $display("probe %-16s pixel (%0d,%0d) vis=%0d rgb=%b expected=%b",
               name, x, y, vis, {R, G, B}, want);
   endtask

   task automatic set_bullet(input int i, input int x, input int y);
      BulletCol[i*10 +: 10] = 10'(x);
      BulletRow[i*9 +: 9]   = 9'(y);
   endtask

   logic [3:0] want_hit_mask;

   initial begin
`ifdef GRID_RENDER_COLLISION_EN
      want_hit_mask = 4'b0100;
`else
      want_hit_mask = 4'b0000;
`endif
      Reset = 1'b1; FrameStart = 1'b0;
      Aliens_Grid = '1; AliensRow = 9'd50; AliensCol = 10'd100;
      PlayerRow = 9'd400; PlayerCol = 10'd1010;
      BulletRow = '0; BulletCol = '0; BulletExists = '0;
      CounterX = '0; CounterY = '0; inDisplayArea = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      checking = 1'b1;

      // Reset state: nothing drawn, and no grid until the first FrameStart
      check("reset_rgb", 32'({R, G, B}), 32'(0));
      check("reset_mask", 32'(CollisionMask), 32'(0));
      probe("no_frame_yet", 100, 50, 1, 3'b000);

      // Full grid at (100,50)
      frame();
      probe("grid_origin", 100, 50, 1, 3'b100);
      probe("grid_gap", 130, 50, 1, 3'b000);
      probe("last_cell", 489, 189, 1, 3'b100);
      probe("last_cell_gapx", 490, 50, 1, 3'b000);
      probe("beyond_cols", 500, 50, 1, 3'b000);
      probe("last_cell_gapy", 100, 190, 1, 3'b000);
      probe("invisible", 100, 50, 0, 3'b000);

      // Single live alien, bit 12 = row 1 col 2
      Aliens_Grid = 50'd1 << 12;
      frame();
      probe("bit12_live", 180, 80, 1, 3'b100);
      probe("bit1_dead", 140, 50, 1, 3'b000);

      // Player near the right edge clips rather than wrapping
      probe("player_right", 1020, 405, 1, 3'b010);
      probe("player_nowrap", 5, 405, 1, 3'b000);
      probe("player_left", 1009, 405, 1, 3'b000);

      // Mid-frame move has no effect until the next FrameStart
      Aliens_Grid = '1;
      frame();
      AliensCol = 10'd300;
      probe("shadow_hold", 100, 50, 1, 3'b100);
      frame();
      probe("shadow_old", 100, 50, 1, 3'b000);
      probe("shadow_new", 300, 50, 1, 3'b100);

      // Grid near the bottom of the row range
      AliensRow = 9'd500;
      frame();
      probe("grid_low", 300, 505, 1, 3'b100);
      probe("grid_nowrap", 300, 2, 1, 3'b000);

      // Bullets: bottom clip and the enable gate
      set_bullet(0, 20, 508);
      set_bullet(1, 40, 40);
      BulletExists = 4'b0001;
      frame();
      probe("bullet_low", 20, 510, 1, 3'b001);
      probe("bullet_nowrap", 20, 2, 1, 3'b000);
      probe("bullet_off", 40, 40, 1, 3'b000);

      // All three sprites overlap; bullet 2 over a live alien
      AliensRow = 9'd50; AliensCol = 10'd100;
      PlayerRow = 9'd50; PlayerCol = 10'd100;
      set_bullet(2, 105, 55);
      BulletExists = 4'b0100;
      frame();
      probe("overlap", 105, 55, 1, 3'b111);
      frame();
      check("hit_mask_frame1", 32'(CollisionMask), 32'(want_hit_mask));
      $display("frame  collision mask=%b expected=%b", CollisionMask, want_hit_mask);
      frame();
      check("hit_mask_frame2", 32'(CollisionMask), 32'(0));
      $display("frame  collision mask=%b expected=%b", CollisionMask, 4'b0000);

      // Asynchronous reset in the middle of a drawn span
      CounterX = 10'd105; CounterY = 10'd55; inDisplayArea = 1'b1;
      repeat (4) @(negedge Clk);
      check("pre_reset_rgb", 32'({R, G, B}), 32'(3'b111));
      FrameStart = 1'b1;
      @(negedge Clk);
      FrameStart = 1'b0;
      repeat (2) @(negedge Clk);
      check("pre_reset_mask", 32'(CollisionMask), 32'(want_hit_mask));
      #2 Reset = 1'b1;
      #1;
      check("async_reset_rgb", 32'({R, G, B}), 32'(0));
      check("async_reset_mask", 32'(CollisionMask), 32'(0));
      $display("reset  mid-line rgb=%b mask=%b expected 000/0000", {R, G, B}, CollisionMask);
      @(negedge Clk);
      inDisplayArea = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      probe("after_reset", 105, 55, 1, 3'b000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
